// File: rtl/lshift_rot_seq.sv
// lshift_rot_seq: sequential left shifter / rotator with a start/busy/done handshake.
//
// Shifts (op=1, zero fill at the LSB) or rotates (op=0, MSB wraps to the LSB)
// an N-bit operand left by a C-bit count. The datapath moves one bit position
// per RUN cycle, which trades latency for area.
//
// Optional build macro LSHIFT_SEQ_FAST_EN: while at least 4 counts remain, a RUN
// cycle moves the data by 4 positions instead of 1. Results are unchanged; only
// the latency drops. With the macro undefined, no 4-step logic is built.
//
// Ports:
//   clk_i    system clock, all state changes on the rising edge
//   rst_i    synchronous, active-high reset; wins over every other input
//   start_i  request, sampled only in IDLE
//   in_i     operand, captured on an accepted start
//   cnt_i    shift amount, captured on an accepted start
//   op_i     1 = shift left logical, 0 = rotate left; captured on an accepted start
//   busy_o   high whenever the state is not IDLE
//   done_o   single-cycle completion pulse (DONE state)
//   out_o    result register; holds the last completed result

module lshift_rot_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned C = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] in_i,
    input  logic [C-1:0] cnt_i,
    input  logic         op_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] out_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e       state_q;
    logic [N-1:0] data_q;
    logic [C-1:0] rem_q;
    logic         op_q;
    logic [N-1:0] out_q;

    // Next value of the datapath for one RUN cycle.
    logic [N-1:0] data_d;
    logic [C-1:0] rem_d;
    logic         last_step;

    always_comb begin
        data_d    = op_q ? {data_q[N-2:0], 1'b0} : {data_q[N-2:0], data_q[N-1]};
        rem_d     = rem_q - C'(1);
        last_step = (rem_q == C'(1));
`ifdef LSHIFT_SEQ_FAST_EN
        if (rem_q >= C'(4)) begin
            data_d    = op_q ? {data_q[N-5:0], 4'b0000} : {data_q[N-5:0], data_q[N-1:N-4]};
            rem_d     = rem_q - C'(4);
            last_step = (rem_q == C'(4));
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        data_q <= in_i;
                        rem_q  <= cnt_i;
                        op_q   <= op_i;
                        if (cnt_i == '0) begin
                            // Zero count: the operand passes straight to the result.
                            out_q   <= in_i;
                            state_q <= StDone;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (last_step) begin
                        out_q   <= data_d;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = (state_q == StDone);
    assign out_o  = out_q;

endmodule

// File: tb/tb_lshift_rot_seq.sv
// Testbench for lshift_rot_seq. Stimulus pushes the expected result and the
// expected done cycle into a queue; a monitor pops and compares on each done pulse.

module tb_lshift_rot_seq;

    localparam int unsigned N = 16;
    localparam int unsigned C = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] din;
    logic [C-1:0] cnt;
    logic         op;
    logic         busy;
    logic         done;
    logic [N-1:0] dout;

    int unsigned  cyc;
    int unsigned  n_tests;
    int unsigned  n_fail;

    typedef struct {
        logic [N-1:0] out;
        int unsigned  cycle;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    lshift_rot_seq #(
        .N(N),
        .C(C)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(start),
        .in_i   (din),
        .cnt_i  (cnt),
        .op_i   (op),
        .busy_o (busy),
        .done_o (done),
        .out_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycles from start acceptance to the done pulse.
    function automatic int unsigned latency(input int unsigned c);
`ifdef LSHIFT_SEQ_FAST_EN
        return 1 + c / 4 + c % 4;
`else
        return 1 + c;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 out=0x%0h, expected no done (cycle %0d)",
                         dout, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_out"}, 32'(dout), 32'(e.out));
                check({e.name, "_cycle"}, cyc, e.cycle);
            end
        end
    end

    // Present one request for a single cycle and record its expected response.
    task automatic issue(input string name, input logic [N-1:0] i, input logic [C-1:0] c,
                         input logic o, input logic [N-1:0] exp_out);
        exp_t e;
        @(posedge clk);
        #1;
        start = 1'b1;
        din   = i;
        cnt   = c;
        op    = o;
        e.out   = exp_out;
        e.cycle = cyc + latency(c);
        e.name  = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble operands after acceptance; they must not disturb the operation.
        din   = ~i;
        cnt   = ~c;
        op    = ~o;
    endtask

    task automatic drain(input string name, input int unsigned max_cyc);
        for (int k = 0; k < int'(max_cyc) && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int unsigned t;
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        cnt   = '0;
        op    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out", 32'(dout), 32'h0000);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);

        // Single-step shift and rotate.
        issue("shl_8001_1", 16'h8001, 4'd1, 1'b1, 16'h0002);
        drain("shl_8001_1", 40);
        issue("rol_8001_1", 16'h8001, 4'd1, 1'b0, 16'h0003);
        drain("rol_8001_1", 40);

        // Multi-step rotate and full-range shift.
        issue("rol_1234_4", 16'h1234, 4'd4, 1'b0, 16'h2341);
        drain("rol_1234_4", 40);
        issue("shl_ffff_15", 16'hFFFF, 4'd15, 1'b1, 16'h8000);
        drain("shl_ffff_15", 40);

        // Zero count: done the next cycle, busy only during that cycle.
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b1;
        din   = 16'hA5A5;
        cnt   = 4'd0;
        op    = 1'b1;
        begin
            exp_t e;
            e.out = 16'hA5A5; e.cycle = t + 1; e.name = "cnt0_a5a5";
            exp_q.push_back(e);
        end
        @(negedge clk);
        check("cnt0_busy_T", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("cnt0_busy_T1", 32'(busy), 32'h1);
        @(negedge clk);
        check("cnt0_busy_T2", 32'(busy), 32'h0);
        drain("cnt0_a5a5", 10);

        // Rotate by 13: exercises the 4-step path when built with the fast macro.
        issue("rol_8421_13", 16'h8421, 4'd13, 1'b0, 16'h3084);
        drain("rol_8421_13", 40);

        // Back-to-back with start held high: second request accepted after DONE.
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b1;
        din   = 16'h0001;
        cnt   = 4'd2;
        op    = 1'b1;
        begin
            exp_t e;
            e.out = 16'h0004; e.cycle = t + 3; e.name = "b2b_first";
            exp_q.push_back(e);
            e.out = 16'h0004; e.cycle = t + 7; e.name = "b2b_second";
            exp_q.push_back(e);
        end
        while (cyc < t + 5) @(posedge clk);
        @(negedge clk);
        check("b2b_out_hold", 32'(dout), 32'h0004);
        check("b2b_busy_run", 32'(busy), 32'h1);
        while (cyc < t + 7) @(posedge clk);
        #1;
        start = 1'b0;
        drain("b2b", 20);
        repeat (4) @(posedge clk);

        // Reset mid-operation: no done, result cleared, back to idle.
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b1;
        din   = 16'h00F0;
        cnt   = 4'd8;
        op    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc < t + 3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_run_out_hold", 32'(dout), 32'h0004);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_run_busy", 32'(busy), 32'h0);
        check("rst_run_out", 32'(dout), 32'h0000);
        check("rst_run_done", 32'(done), 32'h0);
        repeat (20) @(posedge clk);
        check("rst_run_idle_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
